regfile_sequencer: RTL and testbench

Parametrised register file, Y/Z operand latches and HI/LO pair with a built-in three-step micro-sequencer (operand A to Y, operand B plus ALU to Z, Z to destination). It replaces hand-driven Rxin/Rxout/Yin/Zin strobing in the CPU datapath. A single `start` handshake runs a complete register-register ALU operation against an external combinational ALU. Register count, data width and hard-wired-zero R0 are configurable.

---
 rtl/regfile_sequencer_pkg.sv | 38 +++
 rtl/regfile_sequencer_if.sv | 37 +++
 rtl/regfile_sequencer_gp_regfile.sv | 52 +++++
 rtl/regfile_sequencer.sv | 146 ++++++++++++++
 tb/tb_regfile_sequencer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_sequencer_pkg.sv
// Shared CPU definitions: sequencer states, ALU one-hot op indices, defaults.
package cpu_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 16;
  localparam int ALU_OP_W     = 13;

  localparam int ALU_AND  = 0;
  localparam int ALU_OR   = 1;
  localparam int ALU_ADD  = 2;
  localparam int ALU_SUB  = 3;
  localparam int ALU_MUL  = 4;
  localparam int ALU_DIV  = 5;
  localparam int ALU_SHR  = 6;
  localparam int ALU_SHRA = 7;
  localparam int ALU_SHL  = 8;
  localparam int ALU_ROR  = 9;
  localparam int ALU_ROL  = 10;
  localparam int ALU_NEG  = 11;
  localparam int ALU_NOT  = 12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_Y,
    S_EXEC,
    S_WB
  } seq_state_e;

  function automatic logic [ALU_OP_W-1:0] op_onehot(
    input int idx
  );
    logic [ALU_OP_W-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regfile_sequencer_if.sv
// Command handshake and ALU hookup between the controller and
// the register-file sequencer.
interface regfile_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4,
  parameter int OP_W   = 13
);

  logic              start;
  logic [SEL_W-1:0]  sel_a;
  logic [SEL_W-1:0]  sel_b;
  logic [SEL_W-1:0]  sel_c;
  logic              hilo;
  logic [OP_W-1:0]   alu_op;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic [OP_W-1:0]     alu_op_out;
  logic [2*DATA_W-1:0] alu_result;

  modport master (
    output start, sel_a, sel_b, sel_c,
    output hilo, alu_op, alu_result,
    input  busy, done,
    input  alu_a, alu_b, alu_op_out
  );

  modport slave (
    input  start, sel_a, sel_b, sel_c,
    input  hilo, alu_op, alu_result,
    output busy, done,
    output alu_a, alu_b, alu_op_out
  );

endinterface

// File: rtl/regfile_sequencer_gp_regfile.sv
// General-purpose register array: bus and debug read ports,
// sequencer write taking priority over the external write.
module gp_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int R0_ZERO  = 1,
  parameter int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SEL_W-1:0]  bus_sel,
  output logic [DATA_W-1:0] bus_data,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [DATA_W-1:0] rd_data,
  input  logic              seq_we,
  input  logic [SEL_W-1:0]  seq_sel,
  input  logic [DATA_W-1:0] seq_data,
  input  logic              ext_we,
  input  logic [SEL_W-1:0]  ext_sel,
  input  logic [DATA_W-1:0] ext_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (R0_ZERO != 0 && i == 0)
          regs[i] <= '0;
        else if (seq_we && seq_sel == SEL_W'(i))
          regs[i] <= seq_data;
        else if (ext_we && ext_sel == SEL_W'(i))
          regs[i] <= ext_data;
      end
    end
  end

  always_comb begin
    bus_data = regs[bus_sel];
    rd_data  = regs[rd_sel];
    if (R0_ZERO != 0 && bus_sel == '0)
      bus_data = '0;
    if (R0_ZERO != 0 && rd_sel == '0)
      rd_data = '0;
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Register file with Y/Z/HI/LO and a three-step micro-sequencer
// driving one register-register ALU operation per start.
module regfile_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int R0_ZERO  = 1,
  parameter int OP_W     = ALU_OP_W
) (
  input  logic clk,
  input  logic reset,
  regfile_sequencer_if.slave ctl,
  input  logic ext_we,
  input  logic [$clog2(NUM_REGS)-1:0] ext_sel,
  input  logic [DATA_W-1:0] ext_data,
  input  logic [$clog2(NUM_REGS)-1:0] rd_sel,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int SEL_W = $clog2(NUM_REGS);

  seq_state_e state_q, state_d;

  logic [SEL_W-1:0]    a_q, b_q, c_q;
  logic                hilo_q;
  logic [OP_W-1:0]     op_q;
  logic [DATA_W-1:0]   y_q, hi_q, lo_q;
  logic [2*DATA_W-1:0] z_q;

  logic              accept;
  logic              y_we, z_we;
  logic              wb_reg, wb_hilo;
  logic              busy, done;
  logic [OP_W-1:0]   op_out;
  logic [DATA_W-1:0] bus, reg_bus;
  logic [SEL_W-1:0]  bus_sel;

  assign bus_sel = (state_q == S_LOAD_Y) ? a_q : b_q;

  gp_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .R0_ZERO  (R0_ZERO),
    .SEL_W    (SEL_W)
  ) u_regs (
    .clk      (clk),
    .reset    (reset),
    .bus_sel  (bus_sel),
    .bus_data (reg_bus),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data),
    .seq_we   (wb_reg),
    .seq_sel  (c_q),
    .seq_data (z_q[DATA_W-1:0]),
    .ext_we   (ext_we),
    .ext_sel  (ext_sel),
    .ext_data (ext_data)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    y_we    = 1'b0;
    z_we    = 1'b0;
    wb_reg  = 1'b0;
    wb_hilo = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    op_out  = '0;
    bus     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (ctl.start) begin
          accept  = 1'b1;
          state_d = S_LOAD_Y;
        end
      end
      S_LOAD_Y: begin
        busy    = 1'b1;
        bus     = reg_bus;
        y_we    = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        busy    = 1'b1;
        bus     = reg_bus;
        op_out  = op_q;
        z_we    = 1'b1;
        state_d = S_WB;
      end
      S_WB: begin
        busy    = 1'b1;
        done    = 1'b1;
        bus     = z_q[DATA_W-1:0];
        wb_hilo = hilo_q;
        wb_reg  = !hilo_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      hilo_q  <= 1'b0;
      op_q    <= '0;
      y_q     <= '0;
      z_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q    <= ctl.sel_a;
        b_q    <= ctl.sel_b;
        c_q    <= ctl.sel_c;
        hilo_q <= ctl.hilo;
        op_q   <= ctl.alu_op;
      end
      if (y_we)
        y_q <= bus;
      if (z_we)
        z_q <= ctl.alu_result;
      if (wb_hilo) begin
        hi_q <= z_q[2*DATA_W-1:DATA_W];
        lo_q <= z_q[DATA_W-1:0];
      end
    end
  end

  assign ctl.busy       = busy;
  assign ctl.done       = done;
  assign ctl.alu_a      = y_q;
  assign ctl.alu_b      = bus;
  assign ctl.alu_op_out = op_out;
  assign hi             = hi_q;
  assign lo             = lo_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench: 32x16 R0-zero instance and 16x8 plain-R0 instance
// driven against a small combinational ALU model.
module tb_regfile_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  localparam logic [12:0] OP_ADD = 13'h0004;
  localparam logic [12:0] OP_SUB = 13'h0008;
  localparam logic [12:0] OP_MUL = 13'h0010;
  localparam logic [12:0] OP_AND = 13'h0001;

  regfile_sequencer_if #(.DATA_W(32), .SEL_W(4), .OP_W(13)) b0();
  regfile_sequencer_if #(.DATA_W(16), .SEL_W(3), .OP_W(13)) b1();

  logic        ext_we0;
  logic [3:0]  ext_sel0, rd_sel0;
  logic [31:0] ext_data0, rd_data0, hi0, lo0;

  logic        ext_we1;
  logic [2:0]  ext_sel1, rd_sel1;
  logic [15:0] ext_data1, rd_data1, hi1, lo1;

  regfile_sequencer #(
    .DATA_W(32), .NUM_REGS(16), .R0_ZERO(1), .OP_W(13)
  ) u0 (
    .clk(clk), .reset(reset), .ctl(b0),
    .ext_we(ext_we0), .ext_sel(ext_sel0), .ext_data(ext_data0),
    .rd_sel(rd_sel0), .rd_data(rd_data0),
    .hi(hi0), .lo(lo0)
  );

  regfile_sequencer #(
    .DATA_W(16), .NUM_REGS(8), .R0_ZERO(0), .OP_W(13)
  ) u1 (
    .clk(clk), .reset(reset), .ctl(b1),
    .ext_we(ext_we1), .ext_sel(ext_sel1), .ext_data(ext_data1),
    .rd_sel(rd_sel1), .rd_data(rd_data1),
    .hi(hi1), .lo(lo1)
  );

  function automatic logic [63:0] alu64(
    input logic [12:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [63:0] r;
    r = '0;
    case (1'b1)
      op[ALU_AND]: r = {32'h0, a & b};
      op[ALU_OR]:  r = {32'h0, a | b};
      op[ALU_ADD]: r = {32'h0, a} + {32'h0, b};
      op[ALU_SUB]: r = {32'h0, a} - {32'h0, b};
      op[ALU_MUL]: r = {32'h0, a} * {32'h0, b};
      default:     r = '0;
    endcase
    return r;
  endfunction

  assign b0.alu_result = alu64(b0.alu_op_out, b0.alu_a, b0.alu_b);
  assign b1.alu_result = 32'(alu64(b1.alu_op_out,
                                   {16'h0, b1.alu_a},
                                   {16'h0, b1.alu_b}));

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic rd0(input logic [3:0] s, output logic [31:0] v);
    rd_sel0 = s;
    #1;
    v = rd_data0;
  endtask

  task automatic rd1(input logic [2:0] s, output logic [15:0] v);
    rd_sel1 = s;
    #1;
    v = rd_data1;
  endtask

  task automatic ext0(input logic [3:0] s, input logic [31:0] d);
    ext_we0 = 1'b1; ext_sel0 = s; ext_data0 = d;
    tick();
    ext_we0 = 1'b0;
  endtask

  task automatic ext1(input logic [2:0] s, input logic [15:0] d);
    ext_we1 = 1'b1; ext_sel1 = s; ext_data1 = d;
    tick();
    ext_we1 = 1'b0;
  endtask

  task automatic start0(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic h,
                        input logic [12:0] op);
    b0.sel_a = a; b0.sel_b = b; b0.sel_c = c;
    b0.hilo = h; b0.alu_op = op; b0.start = 1'b1;
    tick();
    b0.start = 1'b0;
  endtask

  task automatic op0(input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] c, input logic h,
                     input logic [12:0] op, input string tag);
    start0(a, b, c, h, op);
    tick();
    tick();
    chk({tag, "_done"}, 64'(b0.done), 64'd1);
    tick();
  endtask

  task automatic op1(input logic [2:0] a, input logic [2:0] b,
                     input logic [2:0] c, input logic h,
                     input logic [12:0] op, input string tag);
    b1.sel_a = a; b1.sel_b = b; b1.sel_c = c;
    b1.hilo = h; b1.alu_op = op; b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    tick();
    tick();
    chk({tag, "_done"}, 64'(b1.done), 64'd1);
    tick();
  endtask

  logic [31:0] v0;
  logic [15:0] v1;

  initial begin
    reset = 1'b0;
    b0.start = 1'b0; b0.sel_a = '0; b0.sel_b = '0; b0.sel_c = '0;
    b0.hilo = 1'b0; b0.alu_op = '0;
    b1.start = 1'b0; b1.sel_a = '0; b1.sel_b = '0; b1.sel_c = '0;
    b1.hilo = 1'b0; b1.alu_op = '0;
    ext_we0 = 1'b0; ext_sel0 = '0; ext_data0 = '0; rd_sel0 = '0;
    ext_we1 = 1'b0; ext_sel1 = '0; ext_data1 = '0; rd_sel1 = '0;
    tick();
    tick();

    chk("rst_busy", 64'(b0.busy), 64'd0);
    chk("rst_done", 64'(b0.done), 64'd0);
    chk("rst_opout", 64'(b0.alu_op_out), 64'd0);
    chk("rst_alub", 64'(b0.alu_b), 64'd0);
    chk("rst_hi", 64'(hi0), 64'd0);
    chk("rst_lo", 64'(lo0), 64'd0);
    rd0(4'd1, v0);
    chk("rst_r1", 64'(v0), 64'd0);

    reset = 1'b1;
    tick();

    ext0(4'd1, 32'd5);
    ext0(4'd2, 32'd7);
    rd0(4'd1, v0);
    chk("ext_r1", 64'(v0), 64'd5);

    // ADD with a cycle-by-cycle look, stray start and WB conflict
    start0(4'd1, 4'd2, 4'd3, 1'b0, OP_ADD);
    b0.sel_a = 4'd4; b0.sel_c = 4'd5; b0.alu_op = OP_MUL;
    #1;
    chk("c1_busy", 64'(b0.busy), 64'd1);
    chk("c1_alub", 64'(b0.alu_b), 64'd5);
    chk("c1_opout", 64'(b0.alu_op_out), 64'd0);
    chk("c1_done", 64'(b0.done), 64'd0);
    tick();
    chk("c2_alua", 64'(b0.alu_a), 64'd5);
    chk("c2_alub", 64'(b0.alu_b), 64'd7);
    chk("c2_opout", 64'(b0.alu_op_out), 64'(OP_ADD));
    chk("c2_done", 64'(b0.done), 64'd0);
    b0.start = 1'b1;
    tick();
    b0.start = 1'b0;
    chk("c3_done", 64'(b0.done), 64'd1);
    chk("c3_opout", 64'(b0.alu_op_out), 64'd0);
    ext0(4'd3, 32'hAA);
    chk("c4_done", 64'(b0.done), 64'd0);
    chk("c4_busy", 64'(b0.busy), 64'd0);
    rd0(4'd3, v0);
    chk("add_r3", 64'(v0), 64'd12);
    tick();
    chk("ign_done", 64'(b0.done), 64'd0);
    chk("ign_busy", 64'(b0.busy), 64'd0);
    rd0(4'd5, v0);
    chk("latch_r5", 64'(v0), 64'd0);

    ext0(4'd4, 32'h0001_0000);
    ext0(4'd5, 32'h0001_0000);
    ext0(4'd6, 32'h0000_1234);
    op0(4'd4, 4'd5, 4'd6, 1'b1, OP_MUL, "mul");
    chk("mul_hi", 64'(hi0), 64'd1);
    chk("mul_lo", 64'(lo0), 64'd0);
    rd0(4'd6, v0);
    chk("mul_r6", 64'(v0), 64'h1234);

    op0(4'd1, 4'd2, 4'd7, 1'b0, OP_SUB, "sub");
    rd0(4'd7, v0);
    chk("sub_r7", 64'(v0), 64'hFFFF_FFFE);

    op0(4'd6, 4'd2, 4'd9, 1'b0, OP_AND, "and");
    rd0(4'd9, v0);
    chk("and_r9", 64'(v0), 64'h4);

    op0(4'd1, 4'd2, 4'd0, 1'b0, OP_ADD, "r0seq");
    rd0(4'd0, v0);
    chk("r0_seq", 64'(v0), 64'd0);
    ext0(4'd0, 32'hFFFF);
    rd0(4'd0, v0);
    chk("r0_ext", 64'(v0), 64'd0);

    // abort in EXEC: nothing may land in R8
    start0(4'd1, 4'd2, 4'd8, 1'b0, OP_ADD);
    tick();
    reset = 1'b0;
    #1;
    chk("abt_busy", 64'(b0.busy), 64'd0);
    chk("abt_done", 64'(b0.done), 64'd0);
    chk("abt_alub", 64'(b0.alu_b), 64'd0);
    chk("abt_hi", 64'(hi0), 64'd0);
    chk("abt_lo", 64'(lo0), 64'd0);
    rd0(4'd1, v0);
    chk("abt_r1", 64'(v0), 64'd0);
    rd0(4'd3, v0);
    chk("abt_r3", 64'(v0), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("abt_done2", 64'(b0.done), 64'd0);
    tick();
    rd0(4'd8, v0);
    chk("abt_r8", 64'(v0), 64'd0);

    ext1(3'd1, 16'd3);
    ext1(3'd2, 16'd5);
    op1(3'd1, 3'd2, 3'd3, 1'b0, OP_SUB, "w16sub");
    rd1(3'd3, v1);
    chk("w16_sub", 64'(v1), 64'hFFFE);
    ext1(3'd0, 16'hFFFF);
    rd1(3'd0, v1);
    chk("w16_r0ext", 64'(v1), 64'hFFFF);
    op1(3'd1, 3'd2, 3'd0, 1'b0, OP_ADD, "w16r0");
    rd1(3'd0, v1);
    chk("w16_r0seq", 64'(v1), 64'd8);
    ext1(3'd4, 16'h0100);
    ext1(3'd5, 16'h0100);
    op1(3'd4, 3'd5, 3'd6, 1'b1, OP_MUL, "w16mul");
    chk("w16_hi", 64'(hi1), 64'h1);
    chk("w16_lo", 64'(lo1), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
